remote_cmd_link: RTL and testbench

//  Host-side remote for the knight robot: serialises a 16-bit command over UART (high byte first)
//  and receives one-byte responses (e.g. 0xA5 positive ack) from the robot.

---
 rtl/remote_cmd_link_pkg.sv | 33 +++
 rtl/remote_cmd_link_uart_xcvr.sv | 181 ++++++++++++++++++
 rtl/remote_cmd_link.sv | 91 +++++++++
 tb/tb_remote_cmd_link.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/remote_cmd_link_pkg.sv
// Shared types and constants for the knight-robot remote command link.
// Holds the UART/command state encodings, the default bit period and the ACK byte.
package remote_cmd_link_pkg;

    localparam int         BAUD_DIV_DEFAULT = 2604;
    localparam logic [7:0] ACK_BYTE         = 8'hA5;
    localparam logic [3:0] TX_LAST_BIT      = 4'd9;
    localparam logic [3:0] RX_LAST_BIT      = 4'd7;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_HIGH,
        CMD_LOW
    } cmd_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // 8N1 frame, shifted out LSB first: start bit in bit 0, stop bit in bit 9.
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/remote_cmd_link_uart_xcvr.sv
// 8N1 UART transceiver: independent transmitter and mid-bit-sampling receiver.
// tx_done pulses one cycle after the stop bit ends; rx_rdy is a level cleared by a new start or clr_rx_rdy.
module uart_xcvr
    import remote_cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       txd,
    input  logic       rxd,
    input  logic       clr_rx_rdy,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);

    localparam int             CW        = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    // ---------------- transmitter ----------------
    tx_state_t     tx_state_reg, tx_state_next;
    logic [9:0]    tx_shift_reg, tx_shift_next;
    logic [CW-1:0] tx_baud_reg, tx_baud_next;
    logic [3:0]    tx_bit_reg, tx_bit_next;
    logic          tx_done_reg, tx_done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '1;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_done_reg  <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_baud_reg  <= tx_baud_next;
            tx_bit_reg   <= tx_bit_next;
            tx_done_reg  <= tx_done_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_baud_next  = tx_baud_reg;
        tx_bit_next   = tx_bit_reg;
        tx_done_next  = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (trmt) begin
                    tx_shift_next = tx_frame(tx_data);
                    tx_baud_next  = '0;
                    tx_bit_next   = '0;
                    tx_state_next = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_baud_reg == BAUD_LAST) begin
                    tx_baud_next  = '0;
                    // Ones shifted in keep the line high once the frame is out.
                    tx_shift_next = {1'b1, tx_shift_reg[9:1]};
                    if (tx_bit_reg == TX_LAST_BIT) begin
                        tx_state_next = TX_IDLE;
                        tx_done_next  = 1'b1;
                    end else begin
                        tx_bit_next = tx_bit_reg + 4'd1;
                    end
                end else begin
                    tx_baud_next = tx_baud_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign txd     = tx_shift_reg[0];
    assign tx_done = tx_done_reg;

    // ---------------- receiver ----------------
    logic [2:0]    rx_pipe_reg;
    rx_state_t     rx_state_reg, rx_state_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic          rx_rdy_reg, rx_rdy_next;
    logic [CW-1:0] rx_baud_reg, rx_baud_next;
    logic [3:0]    rx_bit_reg, rx_bit_next;
    logic          rx_bit_in, start_edge;

    // Two synchroniser stages plus one history stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_pipe_reg <= 3'b111;
        end else begin
            rx_pipe_reg <= {rx_pipe_reg[1:0], rxd};
        end
    end

    assign rx_bit_in  = rx_pipe_reg[1];
    assign start_edge = rx_pipe_reg[2] & ~rx_pipe_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_rdy_reg   <= 1'b0;
            rx_baud_reg  <= '0;
            rx_bit_reg   <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            rx_rdy_reg   <= rx_rdy_next;
            rx_baud_reg  <= rx_baud_next;
            rx_bit_reg   <= rx_bit_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_rdy_next   = rx_rdy_reg;
        rx_baud_next  = rx_baud_reg;
        rx_bit_next   = rx_bit_reg;
        if (clr_rx_rdy) begin
            rx_rdy_next = 1'b0;
        end
        case (rx_state_reg)
            RX_IDLE: begin
                if (start_edge) begin
                    rx_state_next = RX_START;
                    rx_baud_next  = '0;
                    rx_rdy_next   = 1'b0;
                end
            end
            RX_START: begin
                if (rx_baud_reg == HALF_LAST) begin
                    rx_baud_next  = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_bit_in ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_baud_reg == BAUD_LAST) begin
                    rx_baud_next  = '0;
                    rx_shift_next = {rx_bit_in, rx_shift_reg[7:1]};
                    if (rx_bit_reg == RX_LAST_BIT) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 4'd1;
                    end
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            RX_STOP: begin
                // Stop-bit value is not checked; the byte is delivered either way.
                if (rx_baud_reg == BAUD_LAST) begin
                    rx_data_next  = rx_shift_reg;
                    rx_rdy_next   = 1'b1;
                    rx_state_next = RX_IDLE;
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign rx_rdy  = rx_rdy_reg;
    assign rx_data = rx_data_reg;

endmodule

// File: rtl/remote_cmd_link.sv
// Host-side remote for the knight robot: sends a 16-bit command high byte first
// over UART and presents the robot's one-byte responses.
module remote_cmd_link
    import remote_cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    cmd_state_t state_reg, state_next;
    logic [7:0] low_byte_reg, low_byte_next;
    logic       cmd_sent_reg, cmd_sent_next;
    logic       trmt;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       clr_rx_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CMD_IDLE;
            low_byte_reg <= '0;
            cmd_sent_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            low_byte_reg <= low_byte_next;
            cmd_sent_reg <= cmd_sent_next;
        end
    end

    // High byte goes straight from the port while idle; low byte is held for the second frame.
    assign tx_byte = (state_reg == CMD_IDLE) ? cmd[15:8] : low_byte_reg;

    always_comb begin
        state_next    = state_reg;
        low_byte_next = low_byte_reg;
        cmd_sent_next = cmd_sent_reg;
        trmt          = 1'b0;
        clr_rx_rdy    = 1'b0;
        case (state_reg)
            CMD_IDLE: begin
                if (send_cmd) begin
                    trmt          = 1'b1;
                    low_byte_next = cmd[7:0];
                    cmd_sent_next = 1'b0;
                    clr_rx_rdy    = 1'b1;
                    state_next    = CMD_HIGH;
                end
            end
            CMD_HIGH: begin
                if (tx_done) begin
                    trmt       = 1'b1;
                    state_next = CMD_LOW;
                end
            end
            CMD_LOW: begin
                if (tx_done) begin
                    cmd_sent_next = 1'b1;
                    state_next    = CMD_IDLE;
                end
            end
            default: state_next = CMD_IDLE;
        endcase
    end

    uart_xcvr #(
        .BAUD_DIV (BAUD_DIV)
    ) u_xcvr (
        .clk        (clk),
        .rst        (rst),
        .trmt       (trmt),
        .tx_data    (tx_byte),
        .tx_done    (tx_done),
        .txd        (TX),
        .rxd        (RX),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_rdy     (resp_rdy),
        .rx_data    (resp)
    );

    assign cmd_sent = cmd_sent_reg;

endmodule

// File: tb/tb_remote_cmd_link.sv
// Directed bench for remote_cmd_link: bench-side UART models on TX and RX with
// expected-byte queues filled at stimulus time and drained as the DUT produces output.
module tb_remote_cmd_link;
    import remote_cmd_link_pkg::*;

    localparam int BAUD      = 16;
    localparam int SENT_WAIT = 20 * BAUD + 20;

    logic        clk;
    logic        rst;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        TX;
    logic        RX;
    logic [7:0]  resp;
    logic        resp_rdy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    bit         tx_abort = 1'b0;

    remote_cmd_link #(.BAUD_DIV(BAUD)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .TX       (TX),
        .RX       (RX),
        .resp     (resp),
        .resp_rdy (resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] c, input bit expect_bytes);
        if (expect_bytes) begin
            exp_tx_q.push_back(c[15:8]);
            exp_tx_q.push_back(c[7:0]);
        end
        cmd      = c;
        send_cmd = 1'b1;
        tick(1);
        send_cmd = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        exp_rx_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            tick(BAUD);
        end
    endtask

    task automatic wait_sent(output int n);
        n = 0;
        while (cmd_sent !== 1'b1 && n < SENT_WAIT) begin
            tick(1);
            n++;
        end
    endtask

    // Bench UART receiver on the DUT's TX line.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge clk);
            if (TX === 1'b0 && rst === 1'b0) begin
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                stop = TX;
                if (tx_abort) begin
                    tx_abort = 1'b0;
                end else begin
                    $display("tx frame: byte=0x%02h stop=%b", b, stop);
                    check("tx_stop", 32'(stop), 32'd1);
                    check("tx_byte_expected", 32'(exp_tx_q.size() != 0), 32'd1);
                    if (exp_tx_q.size() != 0) begin
                        check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
                    end
                end
            end
        end
    end

    // Every new resp_rdy rise must match the next byte the bench put on RX.
    initial begin : rx_monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_rdy === 1'b1 && prev !== 1'b1) begin
                $display("rx response: resp=0x%02h", resp);
                check("resp_expected", 32'(exp_rx_q.size() != 0), 32'd1);
                if (exp_rx_q.size() != 0) begin
                    check("resp_byte", 32'(resp), 32'(exp_rx_q.pop_front()));
                end
            end
            prev = resp_rdy;
        end
    end

    initial begin : stimulus
        int n;
        rst      = 1'b1;
        cmd      = '0;
        send_cmd = 1'b0;
        RX       = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_cmd_sent", 32'(cmd_sent), 32'd0);
        check("rst_resp_rdy", 32'(resp_rdy), 32'd0);
        check("rst_resp", 32'(resp), 32'h00);

        // Calibrate command.
        send(16'h2000, 1'b1);
        check("cal_cmd_sent_low", 32'(cmd_sent), 32'd0);
        wait_sent(n);
        $display("cmd 0x2000: cmd_sent after %0d clocks", n);
        check_range("cal_latency", n, 20 * BAUD, 20 * BAUD + 4);
        check("cal_tx_drained", 32'(exp_tx_q.size()), 32'd0);

        // Positive ack from the robot.
        uart_send(ACK_BYTE);
        tick(4);
        check("ack_drained", 32'(exp_rx_q.size()), 32'd0);
        check("ack_rdy", 32'(resp_rdy), 32'd1);
        check("ack_resp", 32'(resp), 32'(ACK_BYTE));

        // Repeated send_cmd while busy must be ignored.
        send(16'h3A5C, 1'b1);
        check("busy_rdy_cleared", 32'(resp_rdy), 32'd0);
        check("busy_cmd_sent_low", 32'(cmd_sent), 32'd0);
        tick(5 * BAUD);
        send(16'hFFFF, 1'b0);
        tick(8 * BAUD);
        send(16'hFFFF, 1'b0);
        wait_sent(n);
        check("busy_cmd_sent", 32'(cmd_sent), 32'd1);
        tick(12 * BAUD);
        check("busy_cmd_sent_held", 32'(cmd_sent), 32'd1);
        check("busy_tx_drained", 32'(exp_tx_q.size()), 32'd0);

        // Short low glitch on RX is a false start.
        RX = 1'b0;
        tick(BAUD / 4);
        RX = 1'b1;
        tick(2 * BAUD);
        check("glitch_rdy", 32'(resp_rdy), 32'd0);
        check("glitch_resp_kept", 32'(resp), 32'(ACK_BYTE));
        uart_send(8'h5A);
        tick(4);
        check("post_glitch_rdy", 32'(resp_rdy), 32'd1);
        check("post_glitch_resp", 32'(resp), 32'h5A);

        // Command transmit overlapping a response.
        send(16'h1234, 1'b1);
        uart_send(ACK_BYTE);
        tick(4);
        check("dup_rdy", 32'(resp_rdy), 32'd1);
        check("dup_resp", 32'(resp), 32'(ACK_BYTE));
        wait_sent(n);
        check_range("dup_latency", n + 10 * BAUD + 4, 20 * BAUD, 20 * BAUD + 4);
        check("dup_tx_drained", 32'(exp_tx_q.size()), 32'd0);

        // Reset in the middle of the first byte.
        send(16'hBEEF, 1'b0);
        tick(3 * BAUD);
        tx_abort = 1'b1;
        rst      = 1'b1;
        tick(1);
        check("midrst_tx", 32'(TX), 32'd1);
        check("midrst_cmd_sent", 32'(cmd_sent), 32'd0);
        check("midrst_resp_rdy", 32'(resp_rdy), 32'd0);
        check("midrst_resp", 32'(resp), 32'h00);
        rst = 1'b0;
        tick(12 * BAUD);
        check("midrst_tx_idle", 32'(TX), 32'd1);
        check("midrst_cmd_sent_idle", 32'(cmd_sent), 32'd0);

        // Link recovers after the reset.
        send(16'hA55A, 1'b1);
        wait_sent(n);
        check_range("recover_latency", n, 20 * BAUD, 20 * BAUD + 4);
        tick(2 * BAUD);
        check("recover_tx_drained", 32'(exp_tx_q.size()), 32'd0);
        check("final_rx_drained", 32'(exp_rx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
